// File: rtl/uart_pkg.sv
// uart_pkg: shared types, line levels and frame-length helper for uart_byte_tx.
// UART_TX_PARITY_EN adds the PARITY state to the state enum.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int uart_frame_cycles(
    input int clk_div,
    input int data_bits,
    input int parity,
    input int stop_bits
  );
    return clk_div * (1 + data_bits + parity + stop_bits);
  endfunction

endpackage

// File: rtl/uart_byte_tx_baud.sv
// uart_baud_gen: bit-period counter, wraps every CLK_DIV cycles.
// bit_end marks the final cycle of each bit; restart realigns to a new frame.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign bit_end = (cnt == LAST);

  // Free-running divider, cleared on reset or at a frame accept.
  always_ff @(posedge clk) begin
    if (reset || restart)
      cnt <= '0;
    else if (bit_end)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte-serial UART transmitter with valid/ready input.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  localparam int FRAME =
    uart_frame_cycles(CLK_DIV, DATA_BITS, PAR, STOP_BITS);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_t state_q, state_n;
  logic [7:0] shift_q, shift_n;
  logic [2:0] idx_q, idx_n;
  logic       sidx_q, sidx_n;
  logic       tx_n;
  logic       accept;
  logic       restart;
  logic       bit_end;

`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] MASK = 8'((1 << DATA_BITS) - 1);
  logic par_q;

  // Even parity of the accepted byte, held for the PARITY bit.
  always_ff @(posedge clk) begin
    if (reset)
      par_q <= 1'b0;
    else if (accept)
      par_q <= ^(tx_data & MASK);
  end
`endif

  assign tx_ready = (state_q == ST_IDLE) && enable;
  assign busy     = (state_q != ST_IDLE);
  assign accept   = tx_valid && tx_ready;

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .bit_end(bit_end)
  );

  // Frame sequencing and the level the line takes next cycle.
  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    idx_n   = idx_q;
    sidx_n  = sidx_q;
    tx_done = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_n = tx_data;
          restart = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_BIT) begin
            sidx_n = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            shift_n = shift_q >> 1;
            idx_n   = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end)
          state_n = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (sidx_q == LAST_STOP) begin
            tx_done = 1'b1;
            state_n = ST_IDLE;
          end else begin
            sidx_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    tx_n = UART_IDLE_LEVEL;
    unique case (state_n)
      ST_START:  tx_n = UART_START_LEVEL;
      ST_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_n = par_q;
`endif
      default:   tx_n = UART_IDLE_LEVEL;
    endcase
  end

  // State, shifter, indices and the registered serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      sidx_q  <= 1'b0;
      TX      <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      idx_q   <= idx_n;
      sidx_q  <= sidx_n;
      TX      <= tx_n;
    end
  end

  logic [15:0] fcnt;

  // Cycles spent in the current frame, for the length check below.
  always_ff @(posedge clk) begin
    if (reset || state_q == ST_IDLE)
      fcnt <= '0;
    else
      fcnt <= fcnt + 16'd1;
  end

  // tx_done must land on the last cycle of a full-length frame.
  always @(posedge clk) begin
    if (!reset && tx_done)
      assert (fcnt == 16'(FRAME - 1));
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed bench with a cycle-level line model and receiver.
// Honours UART_TX_PARITY_EN to match the parity build of the DUT.
module tb_uart_byte_tx;
  import uart_pkg::*;

  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FA = 40 + 4 * P;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [7:0] da = '0;
  logic [7:0] db = '0;
  logic va = 1'b0;
  logic vb = 1'b0;
  logic ra, txa, busya, donea;
  logic rb, txb, busyb, doneb;

  always #5 clk = ~clk;

  uart_byte_tx #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .tx_data(da), .tx_valid(va), .tx_ready(ra),
    .TX(txa), .busy(busya), .tx_done(donea)
  );

  uart_byte_tx #(.CLK_DIV(CD), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .tx_data(db), .tx_valid(vb), .tx_ready(rb),
    .TX(txb), .busy(busyb), .tx_done(doneb)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef bit lvl_q_t[$];

  // Line levels of one whole frame, one entry per clock cycle.
  function automatic lvl_q_t frame_lvls(input logic [7:0] d,
                                        input int nb, input int ns);
    lvl_q_t q;
    bit par = 1'b0;
    int nper = 1 + nb + P + ns;
    for (int i = 0; i < nb; i++) par ^= d[i];
    for (int c = 0; c < CD * nper; c++) begin
      int per = c / CD;
      bit l;
      if (per == 0) l = 1'b0;
      else if (per <= nb) l = d[per-1];
      else if (P == 1 && per == nb + 1) l = par;
      else l = 1'b1;
      q.push_back(l);
    end
    return q;
  endfunction

  lvl_q_t qa, qb;
  int acca[$], accb[$], dna[$], dnb[$];

  // Model advance and accept logging at each rising edge.
  always @(posedge clk) begin
    if (!reset && va && ra) acca.push_back(cyc);
    if (!reset && vb && rb) accb.push_back(cyc);
    if (reset) qa.delete();
    else if (qa.size() > 0) void'(qa.pop_front());
    else if (enable && va) qa = frame_lvls(da, 8, 1);
    if (reset) qb.delete();
    else if (qb.size() > 0) void'(qb.pop_front());
    else if (enable && vb) qb = frame_lvls(db, 7, 2);
    cyc++;
  end

  logic [7:0] rx_bytes[$];
  bit rx_on = 1'b0;
  int rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic rx_par = 1'b0;
  int zb = 0;

  // Per-cycle compare against the model, plus receiver on line A.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("tx_a", int'(txa), qa.size() > 0 ? int'(qa[0]) : 1);
      chk("busy_a", int'(busya), int'(qa.size() > 0));
      chk("done_a", int'(donea), int'(qa.size() == 1));
      chk("ready_a", int'(ra), int'(qa.size() == 0 && enable));
      chk("tx_b", int'(txb), qb.size() > 0 ? int'(qb[0]) : 1);
      chk("busy_b", int'(busyb), int'(qb.size() > 0));
      chk("done_b", int'(doneb), int'(qb.size() == 1));
      chk("ready_b", int'(rb), int'(qb.size() == 0 && enable));
    end
    if (donea) dna.push_back(cyc);
    if (doneb) dnb.push_back(cyc);
    if (txb == 1'b0) zb++;
    if (reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (txa == 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      for (int i = 0; i < 8; i++)
        if (rx_cnt == CD * (i + 1) + CD / 2) rx_sh[i] = txa;
      if (P == 1 && rx_cnt == CD * 9 + CD / 2) rx_par = txa;
      if (rx_cnt == CD * (9 + P) + CD / 2) begin
        rx_bytes.push_back(rx_sh);
        rx_on = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    int n0 = acca.size();
    int n = 0;
    da = d;
    va = 1'b1;
    while (acca.size() == n0 && n < 300) begin
      tick(1);
      n++;
    end
    if (acca.size() == n0) chk("accept_a_timeout", 0, 1);
    va = 1'b0;
    da = 8'hA5;
  endtask

  task automatic wait_acc_a(input int target);
    int n = 0;
    while (acca.size() < target && n < 300) begin
      tick(1);
      n++;
    end
    if (acca.size() < target) chk("accept_wait_timeout", 0, 1);
  endtask

  task automatic wait_done_a(input int target);
    int n = 0;
    while (dna.size() < target && n < 300) begin
      tick(1);
      n++;
    end
    if (dna.size() < target) chk("done_a_timeout", 0, 1);
  endtask

  function automatic int last_rx();
    if (rx_bytes.size() == 0) return -1;
    return int'(rx_bytes[$]);
  endfunction

  logic [7:0] bb[3] = '{8'h30, 8'h31, 8'h0D};

  initial begin
    int base, dbase, rbase, nacc, ndone, c, z0;
    reset = 1'b1;
    enable = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_tx", int'(txa), 1);
    chk("rst_busy", int'(busya), 0);
    chk("rst_done", int'(donea), 0);
    chk("rst_ready", int'(ra), 1);

    send_a(8'h41);
    wait_done_a(1);
    chk("lat_41", dna[$] - acca[$], FA);
    chk("rx_41", last_rx(), 8'h41);
`ifdef UART_TX_PARITY_EN
    chk("par_41", int'(rx_par), 0);
`endif
    tick(5);

    base = acca.size();
    dbase = dna.size();
    rbase = rx_bytes.size();
    va = 1'b1;
    for (int i = 0; i < 3; i++) begin
      da = bb[i];
      wait_acc_a(base + i + 1);
    end
    va = 1'b0;
    wait_done_a(dbase + 3);
    if (acca.size() >= base + 3 && dna.size() >= dbase + 3 &&
        rx_bytes.size() >= rbase + 3) begin
      chk("b2b_gap1", acca[base+1] - acca[base], 41 + 4 * P);
      chk("b2b_gap2", acca[base+2] - acca[base+1], 41 + 4 * P);
      chk("idle_gap", acca[base+1] - dna[dbase], 1);
      chk("rx_0", int'(rx_bytes[rbase]), 8'h30);
      chk("rx_1", int'(rx_bytes[rbase+1]), 8'h31);
      chk("rx_cr", int'(rx_bytes[rbase+2]), 8'h0D);
    end else begin
      chk("b2b_count", acca.size() - base, 3);
    end
    tick(5);

    ndone = dna.size();
    send_a(8'h42);
    tick(9);
    enable = 1'b0;
    va = 1'b1;
    da = 8'h43;
    wait_done_a(ndone + 1);
    chk("gate_rx", last_rx(), 8'h42);
    nacc = acca.size();
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("gate_ready", int'(ra), 0);
    end
    chk("gate_noacc", acca.size(), nacc);
    enable = 1'b1;
    c = cyc;
    tick(1);
    va = 1'b0;
    chk("gate_acc_edge", acca.size() > nacc ? acca[$] : -1, c);
    wait_done_a(ndone + 2);
    chk("gate_rx2", last_rx(), 8'h43);
    tick(5);

    ndone = dna.size();
    send_a(8'h50);
    tick(14);
    nacc = acca.size();
    reset = 1'b1;
    va = 1'b1;
    da = 8'h99;
    tick(1);
    chk("rst_mid_tx", int'(txa), 1);
    chk("rst_mid_busy", int'(busya), 0);
    chk("rst_mid_done", int'(donea), 0);
    tick(1);
    reset = 1'b0;
    va = 1'b0;
    tick(50);
    chk("rst_noacc", acca.size(), nacc);
    chk("rst_nodone", dna.size(), ndone);
    send_a(8'h55);
    wait_done_a(ndone + 1);
    chk("rx_55", last_rx(), 8'h55);
    tick(5);

    z0 = zb;
    db = 8'hFF;
    vb = 1'b1;
    begin
      int n = 0;
      while (dnb.size() == 0 && n < 300) begin
        tick(1);
        if (accb.size() > 0) vb = 1'b0;
        n++;
      end
    end
    vb = 1'b0;
    if (dnb.size() > 0 && accb.size() > 0) begin
      chk("lat_b", dnb[0] - accb[0], uart_frame_cycles(CD, 7, P, 2));
      chk("lat_b_lit", dnb[0] - accb[0], 40 + 4 * P);
    end else begin
      chk("done_b_timeout", 0, 1);
    end
    chk("b_zeros", zb - z0, 4);
    tick(5);

`ifdef UART_TX_PARITY_EN
    ndone = dna.size();
    send_a(8'h07);
    wait_done_a(ndone + 1);
    chk("par_07", int'(rx_par), 1);
    chk("lat_07", dna[$] - acca[$], 44);
    tick(5);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
